mul_err_meter: RTL

- Downstream stage of the 64x64 multiplier benchmark.
- Consumes streamed pairs of exact and approximate 128-bit products, then computes error statistics over a programmed sample count: error count, max absolute error, sum of absolute error.
- Replaces offline post-processing of simulation output dumps for approximate-multiplier quality measurement.

---
 rtl/mul_err_meter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mul_err_meter.sv
// mul_err_meter: streaming error statistics for exact/approximate product pairs (optional MUL_ERR_BITFLIP_EN adds bitflip_sum)
module mul_err_meter #(
  parameter int W     = 128,
  parameter int CNT_W = 32,
  parameter int SUM_W = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_exact,
  input  logic [W-1:0]     in_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     max_abs_err,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic             sum_sat
`ifdef MUL_ERR_BITFLIP_EN
  ,
  output logic [CNT_W+7:0] bitflip_sum
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, cnt_q, err_q;
  logic             v1_q, v2_q, ne_q, sat_q;
  logic [W-1:0]     ex_q, ap_q, d_q, max_q;
  logic [SUM_W-1:0] sum_q;
  logic [W:0]       diff;
  logic [SUM_W:0]   sum_n;
  logic             go, accept, last;
  assign go       = start && (state_q == IDLE || state_q == DONE);
  assign in_ready = state_q == RUN && cnt_q < target_q;
  assign accept   = in_valid && in_ready;
  assign last     = cnt_q + CNT_W'(1) == target_q;
  assign diff     = {1'b0, ex_q} - {1'b0, ap_q};
  assign sum_n    = {1'b0, sum_q} + {{(SUM_W - W + 1){1'b0}}, d_q};
  // Run sequencing: start only from IDLE/DONE, drain waits for both pipeline stages to empty
  always_comb begin
    state_d = go ? (num_samples == '0 ? DONE : RUN)
            : (state_q == RUN && accept && last) ? DRAIN
            : (state_q == DRAIN && !v1_q && !v2_q) ? DONE
            : state_q;
  end
  // Capture accepted pair, then abs difference, then fold into the statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      ne_q     <= 1'b0;
      sat_q    <= 1'b0;
      ex_q     <= '0;
      ap_q     <= '0;
      d_q      <= '0;
      max_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q <= state_d;
      v1_q    <= accept;
      v2_q    <= v1_q;
      if (accept) begin
        ex_q <= in_exact;
        ap_q <= in_approx;
      end
      if (v1_q) begin
        d_q  <= diff[W] ? ~diff[W-1:0] + W'(1) : diff[W-1:0];
        ne_q <= ex_q != ap_q;
      end
      if (go) begin
        target_q <= num_samples;
        cnt_q    <= '0;
        err_q    <= '0;
        max_q    <= '0;
        sum_q    <= '0;
        sat_q    <= 1'b0;
      end else begin
        if (accept) cnt_q <= cnt_q + CNT_W'(1);
        if (v2_q) begin
          err_q <= err_q + {{(CNT_W - 1){1'b0}}, ne_q};
          max_q <= d_q > max_q ? d_q : max_q;
          sum_q <= sum_n[SUM_W] ? '1 : sum_n[SUM_W-1:0];
          sat_q <= sat_q | sum_n[SUM_W];
        end
      end
    end
  end
`ifdef MUL_ERR_BITFLIP_EN
  logic [7:0]       pc_q;
  logic [CNT_W+7:0] bf_q;
  logic [CNT_W+8:0] bf_n;
  assign bf_n = {1'b0, bf_q} + {{(CNT_W + 1){1'b0}}, pc_q};
  // Popcount of differing bits, accumulated alongside the other statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      bf_q <= '0;
    end else begin
      if (v1_q) pc_q <= 8'($countones(ex_q ^ ap_q));
      if (go) bf_q <= '0;
      else if (v2_q) bf_q <= bf_n[CNT_W+8] ? '1 : bf_n[CNT_W+7:0];
    end
  end
  assign bitflip_sum = bf_q;
`endif
  assign busy        = state_q == RUN || state_q == DRAIN;
  assign done        = state_q == DONE;
  assign sample_cnt  = cnt_q;
  assign err_cnt     = err_q;
  assign max_abs_err = max_q;
  assign sum_abs_err = sum_q;
  assign sum_sat     = sat_q;
endmodule
